// File: rtl/mul2_ctrl_pkg.sv
// Shared types and constants for the MUL2 pass sequencer.
package mul2_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RESULT = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam int MUL2_LAT   = 1;
   localparam int DEF_PASS_W = 4;
   localparam int DEF_JCNT_W = 16;

endpackage

// File: rtl/mul2_pass_ctrl.sv
// Sequences k back-to-back MUL2 squaring passes per accepted job.
// Steers the input mux, capture strobes and the result handshake.
module mul2_pass_ctrl
   import mul2_ctrl_pkg::*;
#(
   parameter int PASS_W = DEF_PASS_W,
   parameter int JCNT_W = DEF_JCNT_W
) (
   input  logic              clk_mul,
   input  logic              rst_mul_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PASS_W-1:0] cfg_passes,
   output logic              in_we,
   input  logic              abort,
   output logic              sel_fb,
   output logic              en_mul,
   output logic              res_we,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              err,
   output logic [JCNT_W-1:0] job_cnt
);

   state_t            r_state;
   logic [PASS_W-1:0] r_p;
   logic [PASS_W-1:0] r_k;
   logic [JCNT_W-1:0] r_jcnt;
   logic              r_err;

   logic w_idle;
   logic w_issue;
   logic w_result;
   logic w_hold;
   logic w_accept;
   logic w_first;

   assign w_idle   = (r_state == IDLE);
   assign w_issue  = (r_state == ISSUE);
   assign w_result = (r_state == RESULT);
   assign w_hold   = (r_state == HOLD);
   assign w_accept = in_valid & in_ready;
   assign w_first  = (r_p == PASS_W'(1));

   always_ff @(posedge clk_mul or negedge rst_mul_n) begin
      if (!rst_mul_n) begin
         r_state <= IDLE;
         r_p     <= '0;
         r_k     <= '0;
         r_jcnt  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         if (abort && !w_idle) begin
            r_state <= IDLE;
         end else begin
            unique case (r_state)
               IDLE: begin
                  if (w_accept) begin
                     if (cfg_passes == '0) begin
                        r_err <= 1'b1;
                     end else begin
                        r_k     <= cfg_passes;
                        r_p     <= PASS_W'(1);
                        r_state <= ISSUE;
                     end
                  end
               end
               ISSUE: begin
                  if (r_p == r_k) r_state <= RESULT;
                  else            r_p     <= r_p + PASS_W'(1);
               end
               RESULT: begin
                  if (out_ready) begin
                     r_jcnt  <= r_jcnt + JCNT_W'(1);
                     r_state <= IDLE;
                  end else begin
                     r_state <= HOLD;
                  end
               end
               HOLD: begin
                  if (out_ready) begin
                     r_jcnt  <= r_jcnt + JCNT_W'(1);
                     r_state <= IDLE;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   // MUL2 output is only valid in RESULT; abort masks it that cycle.
   assign in_ready  = w_idle & ~abort;
   assign in_we     = w_accept;
   assign en_mul    = w_issue;
   assign sel_fb    = w_issue & ~w_first;
   assign res_we    = w_result & ~abort;
   assign out_valid = (w_result | w_hold) & ~abort;
   assign busy      = ~w_idle;
   assign err       = r_err;
   assign job_cnt   = r_jcnt;

endmodule

// File: tb/tb_mul2_pass_ctrl.sv
// Directed bench for mul2_pass_ctrl: vector table plus reset/wrap sequences.
module tb_mul2_pass_ctrl;

   localparam int PW = 4;
   localparam int JW = 2;

   logic          clk_mul = 1'b0;
   logic          rst_mul_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [PW-1:0] cfg_passes = '0;
   logic          in_we;
   logic          abort = 1'b0;
   logic          sel_fb;
   logic          en_mul;
   logic          res_we;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          busy;
   logic          err;
   logic [JW-1:0] job_cnt;

   int total = 0;
   int bad   = 0;

   mul2_pass_ctrl #(.PASS_W(PW), .JCNT_W(JW)) dut (
      .clk_mul    (clk_mul),
      .rst_mul_n  (rst_mul_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .cfg_passes (cfg_passes),
      .in_we      (in_we),
      .abort      (abort),
      .sel_fb     (sel_fb),
      .en_mul     (en_mul),
      .res_we     (res_we),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .err        (err),
      .job_cnt    (job_cnt)
   );

   always #5 clk_mul = ~clk_mul;

   typedef struct {
      logic          iv;
      logic [PW-1:0] cfg;
      logic          ab;
      logic          ordy;
      logic [7:0]    exp;
      logic [JW-1:0] jc;
   } vec_t;

   vec_t vq[$];

   function automatic logic [7:0] outs();
      return {in_ready, in_we, en_mul, sel_fb,
              res_we, out_valid, busy, err};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic iv, input logic [PW-1:0] cfg,
                      input logic ab, input logic ordy,
                      input logic [7:0] exp, input logic [JW-1:0] jc);
      vec_t v;
      v.iv = iv; v.cfg = cfg; v.ab = ab; v.ordy = ordy;
      v.exp = exp; v.jc = jc;
      vq.push_back(v);
   endtask

   task automatic drive(input logic iv, input logic [PW-1:0] cfg,
                        input logic ab, input logic ordy);
      @(posedge clk_mul);
      #1;
      in_valid   = iv;
      cfg_passes = cfg;
      abort      = ab;
      out_ready  = ordy;
      @(negedge clk_mul);
   endtask

   // exp = {in_ready,in_we,en_mul,sel_fb,res_we,out_valid,busy,err}
   initial begin
      add(1, 1, 0, 0, 8'b1100_0000, 0);
      add(0, 0, 0, 0, 8'b0010_0010, 0);
      add(0, 0, 0, 1, 8'b0000_1110, 0);
      add(0, 0, 0, 0, 8'b1000_0000, 1);
      add(1, 0, 0, 0, 8'b1100_0000, 1);
      add(0, 0, 0, 0, 8'b1000_0001, 1);
      add(0, 0, 0, 0, 8'b1000_0000, 1);
      add(1, 3, 0, 0, 8'b1100_0000, 1);
      add(0, 0, 0, 0, 8'b0010_0010, 1);
      add(0, 0, 0, 0, 8'b0011_0010, 1);
      add(0, 0, 0, 0, 8'b0011_0010, 1);
      add(0, 0, 0, 0, 8'b0000_1110, 1);
      for (int i = 0; i < 4; i++)
         add(0, 0, 0, 0, 8'b0000_0110, 1);
      add(0, 0, 0, 1, 8'b0000_0110, 1);
      add(0, 0, 0, 0, 8'b1000_0000, 2);
      add(1, 4, 0, 0, 8'b1100_0000, 2);
      add(0, 0, 0, 0, 8'b0010_0010, 2);
      add(0, 0, 1, 0, 8'b0011_0010, 2);
      add(1, 1, 0, 0, 8'b1100_0000, 2);
      add(0, 0, 0, 0, 8'b0010_0010, 2);
      add(0, 0, 1, 1, 8'b0000_0010, 2);
      add(1, 1, 1, 0, 8'b0000_0000, 2);
      add(1, 2, 0, 0, 8'b1100_0000, 2);
      add(0, 0, 0, 0, 8'b0010_0010, 2);
      add(0, 0, 0, 0, 8'b0011_0010, 2);
      add(0, 0, 0, 1, 8'b0000_1110, 2);
      add(0, 0, 0, 0, 8'b1000_0000, 3);

      #12;
      chk("rst_outs", 32'(outs() & 8'b0111_1111), 32'd0);
      chk("rst_jcnt", 32'(job_cnt), 32'd0);
      @(posedge clk_mul);
      #1 rst_mul_n = 1'b1;
      @(negedge clk_mul);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].iv, vq[i].cfg, vq[i].ab, vq[i].ordy);
         chk($sformatf("vec%0d_outs", i), 32'(outs()),
             32'(vq[i].exp));
         chk($sformatf("vec%0d_jcnt", i), 32'(job_cnt),
             32'(vq[i].jc));
      end

      // fourth completion wraps the 2-bit counter
      drive(1, 1, 0, 0);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 1);
      chk("wrap_res_we", 32'(res_we), 32'd1);
      drive(0, 0, 0, 0);
      chk("wrap_jcnt", 32'(job_cnt), 32'd0);
      chk("wrap_in_ready", 32'(in_ready), 32'd1);

      drive(1, 1, 0, 0);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      chk("post_wrap_jcnt", 32'(job_cnt), 32'd1);

      // async reset in the middle of a k=5 job
      drive(1, 5, 0, 0);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      chk("pre_rst_sel_fb", 32'(sel_fb), 32'd1);
      #2 rst_mul_n = 1'b0;
      #1;
      chk("async_rst_outs", 32'(outs() & 8'b0111_1111), 32'd0);
      chk("async_rst_jcnt", 32'(job_cnt), 32'd0);
      @(posedge clk_mul);
      #1 rst_mul_n = 1'b1;
      @(negedge clk_mul);
      chk("post_rst_in_ready", 32'(outs()), 32'(8'b1000_0000));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
